// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit FIFO and its launch controller.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer/transmitter-facing bundle of uart_tx_fifo.
// UART_TX_FIFO_STATS_EN adds the drop_count and max_count statistics signals.
interface uart_tx_fifo_if import uart_pkg::*; #(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = UART_ADDR_WIDTH
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  tx_enable;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_busy;
  logic                  launch_err;
`ifdef UART_TX_FIFO_STATS_EN
  logic [15:0]           drop_count;
  logic [ADDR_WIDTH:0]   max_count;

  modport master (output wr_en, wr_data, tx_busy,
                  input  full, empty, count, overflow, tx_enable, tx_data, launch_err,
                         drop_count, max_count);
  modport slave  (input  wr_en, wr_data, tx_busy,
                  output full, empty, count, overflow, tx_enable, tx_data, launch_err,
                         drop_count, max_count);
`else
  modport master (output wr_en, wr_data, tx_busy,
                  input  full, empty, count, overflow, tx_enable, tx_data, launch_err);
  modport slave  (input  wr_en, wr_data, tx_busy,
                  output full, empty, count, overflow, tx_enable, tx_data, launch_err);
`endif
endinterface

// File: rtl/uart_fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read, pointers owned by the parent.
module uart_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch FSM feeding a UART transmitter, paced on tx_busy.
// UART_TX_FIFO_STATS_EN adds a saturating drop counter and an occupancy high-water mark.
module uart_tx_fifo import uart_pkg::*; #(
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int DEPTH        = UART_FIFO_DEPTH,
  parameter int ADDR_WIDTH   = UART_ADDR_WIDTH,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic           clk,
  input  logic           reset_tx,
  uart_tx_fifo_if.slave  bus
);
  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [TW-1:0]       TMO_C   = TW'(BUSY_TIMEOUT - 1);

  tx_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic                  tx_enable_q, tx_enable_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  launch_err_q, launch_err_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  wr_accept, pop;
  logic [DATA_WIDTH-1:0] rd_data;

  // full is the registered flag, so a pop in the same cycle cannot rescue a write
  assign wr_accept = bus.wr_en && !full_q;

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr_q),
    .wdata (bus.wr_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    tx_data_d    = tx_data_q;
    tx_enable_d  = 1'b0;
    launch_err_d = 1'b0;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q && !bus.tx_busy) begin
          pop         = 1'b1;
          tx_enable_d = 1'b1;
          tx_data_d   = rd_data;
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.tx_busy) begin
          state_d = WAIT_LO;
        end else if (timer_q == TMO_C) begin
          // transmitter never acknowledged: the byte is dropped, not retried
          launch_err_d = 1'b1;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!bus.tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop       ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d     = (count_d == DEPTH_C);
    empty_d    = (count_d == '0);
    overflow_d = bus.wr_en && full_q;
  end

  always_ff @(posedge clk or posedge reset_tx) begin
    if (reset_tx) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      overflow_q   <= 1'b0;
      tx_enable_q  <= 1'b0;
      tx_data_q    <= '0;
      launch_err_q <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      overflow_q   <= overflow_d;
      tx_enable_q  <= tx_enable_d;
      tx_data_q    <= tx_data_d;
      launch_err_q <= launch_err_d;
      timer_q      <= timer_d;
    end
  end

  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.tx_enable  = tx_enable_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.launch_err = launch_err_q;

`ifdef UART_TX_FIFO_STATS_EN
  logic [15:0]         drop_count_q, drop_count_d;
  logic [ADDR_WIDTH:0] max_count_q, max_count_d;

  always_comb begin
    drop_count_d = drop_count_q;
    if (overflow_d && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 1'b1;
    max_count_d = (count_d > max_count_q) ? count_d : max_count_q;
  end

  always_ff @(posedge clk or posedge reset_tx) begin
    if (reset_tx) begin
      drop_count_q <= '0;
      max_count_q  <= '0;
    end else begin
      drop_count_q <= drop_count_d;
      max_count_q  <= max_count_d;
    end
  end

  assign bus.drop_count = drop_count_q;
  assign bus.max_count  = max_count_q;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple busy-pulse transmitter model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset_tx = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_if bus ();
  uart_tx_fifo dut (.clk(clk), .reset_tx(reset_tx), .bus(bus));

  int errors = 0;
  int checks = 0;

  // transmitter model: busy for busy_len cycles after sampling enable
  logic force_busy = 1'b0;
  logic model_on   = 1'b0;
  int   busy_len   = 0;
  int   busy_cnt   = 0;
  always @(posedge clk) begin
    if (model_on && bus.tx_enable) busy_cnt <= busy_len;
    else if (busy_cnt > 0)         busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = force_busy | (busy_cnt != 0);

  logic [7:0] launched[$];
  logic [7:0] last_launch = 8'h00;
  int ovf_cnt = 0, err_cnt = 0, unstable = 0, launch_busy = 0;
  always @(negedge clk) begin
    if (!reset_tx) begin
      if (bus.tx_enable) begin
        launched.push_back(bus.tx_data);
        last_launch = bus.tx_data;
        if (bus.tx_busy) launch_busy++;
      end else if (bus.tx_busy && bus.tx_data !== last_launch) begin
        unstable++;
      end
      if (bus.overflow)   ovf_cnt++;
      if (bus.launch_err) err_cnt++;
    end
  end

  task automatic push(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_count(input int n, input int budget, output bit ok);
    int c = 0;
    while (launched.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (launched.size() >= n);
  endtask

  task automatic test_reset;
    bus.wr_en = 1'b0; bus.wr_data = 8'h00;
    reset_tx = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    checks++; if (bus.tx_enable !== 1'b0) begin errors++; $display("FAIL reset_tx_enable: got %b want 0", bus.tx_enable); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    checks++; if (bus.launch_err !== 1'b0) begin errors++; $display("FAIL reset_launch_err: got %b want 0", bus.launch_err); end
    reset_tx = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int base = launched.size();
    int e0 = err_cnt;
    model_on = 1'b1; busy_len = 3;
    push(8'hA3);
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL single_count1: got %0d want 1", bus.count); end
    checks++; if (bus.tx_enable !== 1'b0) begin errors++; $display("FAIL single_no_fallthru: got %b want 0", bus.tx_enable); end
    @(negedge clk);
    checks++; if (bus.tx_enable !== 1'b1) begin errors++; $display("FAIL single_enable: got %b want 1", bus.tx_enable); end
    checks++; if (bus.tx_data !== 8'hA3) begin errors++; $display("FAIL single_data: got %h want a3", bus.tx_data); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL single_count0: got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b want 1", bus.empty); end
    @(negedge clk);
    checks++; if (bus.tx_enable !== 1'b0) begin errors++; $display("FAIL single_enable_width: got %b want 0", bus.tx_enable); end
    repeat (15) @(negedge clk);
    checks++; if (launched.size() - base !== 1) begin errors++; $display("FAIL single_launches: got %0d want 1", launched.size() - base); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL single_launch_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_three;
    int base = launched.size();
    int u0 = unstable, lb0 = launch_busy;
    bit ok;
    model_on = 1'b1; busy_len = 20;
    push(8'h01); push(8'h02); push(8'h03);
    wait_count(base + 3, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL three_timeout: got %0d launches want 3", launched.size() - base); end
    repeat (30) @(negedge clk);
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (launched[base+i] !== 8'(i + 1)) begin
          errors++; $display("FAIL three_order[%0d]: got %h want %h", i, launched[base+i], 8'(i + 1));
        end
      end
    end
    checks++; if (launched.size() - base !== 3) begin errors++; $display("FAIL three_launches: got %0d want 3", launched.size() - base); end
    checks++; if (launch_busy - lb0 !== 0) begin errors++; $display("FAIL three_launch_while_busy: got %0d want 0", launch_busy - lb0); end
    checks++; if (unstable - u0 !== 0) begin errors++; $display("FAIL three_data_stable: got %0d changes want 0", unstable - u0); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL three_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_overflow;
    int base, o0 = ovf_cnt, bad = 0;
    bit ok;
    model_on = 1'b0; force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", bus.full); end
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL ovf_count16: got %0d want 16", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", bus.overflow); end
    push(8'h20);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b want 1", bus.overflow); end
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL ovf_count_hold: got %0d want 16", bus.count); end
    @(negedge clk);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_width: got %b want 0", bus.overflow); end
    checks++; if (ovf_cnt - o0 !== 1) begin errors++; $display("FAIL ovf_pulses: got %0d want 1", ovf_cnt - o0); end
`ifdef UART_TX_FIFO_STATS_EN
    checks++; if (bus.drop_count !== 16'd1) begin errors++; $display("FAIL ovf_drop_count: got %0d want 1", bus.drop_count); end
    checks++; if (bus.max_count !== 5'd16) begin errors++; $display("FAIL ovf_max_count: got %0d want 16", bus.max_count); end
`endif
    base = launched.size();
    force_busy = 1'b0; model_on = 1'b1; busy_len = 2;
    wait_count(base + 16, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_drain_timeout: got %0d launches want 16", launched.size() - base); end
    repeat (20) @(negedge clk);
    if (ok) begin
      checks++; if (launched[base] !== 8'h10) begin errors++; $display("FAIL ovf_first_out: got %h want 10", launched[base]); end
      for (int i = 0; i < 16; i++) if (launched[base+i] !== 8'h10 + 8'(i)) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL ovf_order: got %0d wrong bytes want 0", bad); end
    end
    checks++; if (launched.size() - base !== 16) begin errors++; $display("FAIL ovf_drained: got %0d want 16", launched.size() - base); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_timeout;
    int e0 = err_cnt, c = 0;
    model_on = 1'b0; force_busy = 1'b0;
    push(8'h55); push(8'h66);
    while (!bus.tx_enable && c < 10) begin @(negedge clk); c++; end
    checks++; if (bus.tx_enable !== 1'b1) begin errors++; $display("FAIL tmo_launch1: got %b want 1", bus.tx_enable); end
    checks++; if (bus.tx_data !== 8'h55) begin errors++; $display("FAIL tmo_data1: got %h want 55", bus.tx_data); end
    repeat (8) @(negedge clk);
    checks++; if (bus.launch_err !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b want 0", bus.launch_err); end
    @(negedge clk);
    checks++; if (bus.launch_err !== 1'b1) begin errors++; $display("FAIL tmo_err1: got %b want 1", bus.launch_err); end
    @(negedge clk);
    checks++; if (bus.launch_err !== 1'b0) begin errors++; $display("FAIL tmo_err_width: got %b want 0", bus.launch_err); end
    checks++; if (bus.tx_enable !== 1'b1) begin errors++; $display("FAIL tmo_launch2: got %b want 1", bus.tx_enable); end
    checks++; if (bus.tx_data !== 8'h66) begin errors++; $display("FAIL tmo_data2: got %h want 66", bus.tx_data); end
    repeat (9) @(negedge clk);
    checks++; if (bus.launch_err !== 1'b1) begin errors++; $display("FAIL tmo_err2: got %b want 1", bus.launch_err); end
    repeat (3) @(negedge clk);
    checks++; if (err_cnt - e0 !== 2) begin errors++; $display("FAIL tmo_err_pulses: got %0d want 2", err_cnt - e0); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL tmo_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_reset_mid;
    int base = launched.size(), n;
    bit ok;
    model_on = 1'b1; busy_len = 20;
    for (int i = 0; i < 10; i++) push(8'hC0 + 8'(i));
    wait_count(base + 1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_no_launch: got %0d launches want 1", launched.size() - base); end
    repeat (5) @(negedge clk);
    reset_tx = 1'b1;
    #1;
    checks++; if (bus.tx_enable !== 1'b0) begin errors++; $display("FAIL rstmid_enable: got %b want 0", bus.tx_enable); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b want 1", bus.empty); end
    repeat (2) @(negedge clk);
    reset_tx = 1'b0;
    n = launched.size();
    repeat (60) @(negedge clk);
    checks++; if (launched.size() !== n) begin errors++; $display("FAIL rstmid_stale: got %0d launches want 0", launched.size() - n); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL rstmid_count_after: got %0d want 0", bus.count); end
  endtask

  task automatic test_wrap;
    int base = launched.size(), o0 = ovf_cnt, bad = 0;
    bit ok;
    model_on = 1'b1; busy_len = 3;
    for (int g = 0; g < 10; g++) begin
      for (int j = 0; j < 4; j++) push(8'(g * 4 + j));
      repeat (20) @(negedge clk);
    end
    wait_count(base + 40, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: got %0d launches want 40", launched.size() - base); end
    repeat (10) @(negedge clk);
    if (ok) begin
      for (int i = 0; i < 40; i++) if (launched[base+i] !== 8'(i)) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_order: got %0d wrong bytes want 0", bad); end
    end
    checks++; if (launched.size() - base !== 40) begin errors++; $display("FAIL wrap_launches: got %0d want 40", launched.size() - base); end
    checks++; if (ovf_cnt - o0 !== 0) begin errors++; $display("FAIL wrap_overflow: got %0d want 0", ovf_cnt - o0); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", bus.empty); end
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    test_reset();
    test_single();
    test_three();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer and launch controller directly upstream of the UART transmitter. Accepts bytes from a producer through a write strobe, stores them in a circular FIFO, and hands them one at a time to the transmitter's enable/i_data inputs. It paces each launch on the transmitter's busy output. This decouples bursty producers from the serial line rate.

Parameters:
- DATA_WIDTH, 8, width of one UART character.
- DEPTH, 16, FIFO entries; must be a power of 2, minimum 2.
- ADDR_WIDTH, 4, log2(DEPTH).
- BUSY_TIMEOUT, 8, cycles to wait for tx_busy to rise after a launch before abandoning the wait.

Ports:
- clk  input  1  single system clock; all logic on posedge.
- reset_tx  input  1  asynchronous, active-high reset; clears FIFO and FSM.
- wr_en  input  1  producer write strobe; one byte per cycle when high.
- wr_data  input  DATA_WIDTH  byte to enqueue.
- full  output  1  count == DEPTH (registered).
- empty  output  1  count == 0 (registered).
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse when a write is dropped.
- tx_enable  output  1  one-cycle launch strobe to transmitter enable.
- tx_data  output  DATA_WIDTH  byte to transmitter i_data; stable from launch until tx_busy falls.
- tx_busy  input  1  transmitter o_busy.
- launch_err  output  1  one-cycle pulse when a launch times out.

Behaviour:
- Reset values (asynchronous): count=0, rd/wr pointers=0, empty=1, full=0, overflow=0, tx_enable=0, tx_data=0, launch_err=0, state=IDLE. Memory contents are don't-care.
- Write: wr_en && !full stores wr_data at wr_ptr, wr_ptr++ (wraps DEPTH-1 to 0), count++.
- Write while full: wr_en && full drops the byte with no pointer or count change; overflow=1 the next cycle for one cycle. A pop in the same cycle does not rescue the write; full is sampled as registered.
- Pop occurs only on the IDLE→LAUNCH transition: mem[rd_ptr] is registered into tx_data, rd_ptr++ (wraps), count--.
- Simultaneous write and pop: count unchanged; both pointers advance.
- No fall-through. A write accepted at edge N makes tx_enable high after edge N+1 at the earliest (2-cycle latency).
- FSM states:
  - IDLE: if !empty && !tx_busy → pop, tx_enable<=1, go LAUNCH. Otherwise stay.
  - LAUNCH: tx_enable<=0, timer<=0, go WAIT_HI. tx_enable is high for exactly this one cycle.
  - WAIT_HI: if tx_busy → WAIT_LO. Else timer++. If timer==BUSY_TIMEOUT-1 → launch_err pulse, go IDLE; the byte is considered consumed and is not retried.
  - WAIT_LO: if !tx_busy → IDLE.
- Back-to-back bytes: minimum one IDLE cycle between tx_busy falling and the next tx_enable.
- tx_busy already high in IDLE (e.g. transmitter still finishing): hold in IDLE; no launch.
- Reset mid-transfer: queued bytes are discarded and tx_enable deasserts immediately. The transmitter's own reset is independent.
- count arithmetic is ADDR_WIDTH+1 bits, so DEPTH is representable. Pointers are ADDR_WIDTH bits with natural wrap.

Optional Feature:
Macro UART_TX_FIFO_STATS_EN.
- Defined: adds output drop_count [15:0], reset to 0. It increments on each dropped write and saturates at 16'hFFFF. It also adds output max_count [ADDR_WIDTH:0], a high-water mark of count, reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (IDLE, LAUNCH, WAIT_HI, WAIT_LO);
  - UART_DATA_WIDTH = 8;
  - default FIFO depth constant.
- One sub-module, uart_fifo_mem: a DEPTH x DATA_WIDTH register array with synchronous write port and asynchronous read port, addressed by the pointers from the parent.
- Pointer, count and FSM logic stay in uart_tx_fifo.

Test Plan:
- Reset then single write 8'hA3 with tx_busy=0 → tx_enable pulses once 2 cycles later with tx_data=8'hA3; count goes 1→0; empty returns to 1.
- Write 3 bytes (8'h01,8'h02,8'h03); model tx_busy high 20 cycles after each enable → exactly 3 tx_enable pulses, in order. Each pulse occurs only after tx_busy has fallen, and tx_data is stable during busy.
- Write 17 bytes back-to-back with tx_busy held 1 → full=1 after 16 writes; 17th is dropped with one overflow pulse; count=16; first byte out is the first written.
- Launch with tx_busy never rising → launch_err pulses BUSY_TIMEOUT cycles after entering WAIT_HI; FSM proceeds to the next byte.
- Fill 10 bytes, assert reset_tx mid WAIT_LO → tx_enable=0, count=0, empty=1 immediately. After reset release, no stale byte is launched.
- Pointer wrap: push and drain 40 sequential bytes (0..39) with writes interleaved during transmission → output sequence is exactly 0..39; no overflow pulses.
